// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - mining job controller: nonce sweep, pipeline drain, result FIFO
// Optional time rolling is enabled by defining NONCE_SCHED_TIME_ROLL_EN.
module nonce_scheduler #(
    parameter int PIPE_DEPTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_ROLL   = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [255:0] job_digest,
    input  logic [31:0]  job_merkle,
    input  logic [31:0]  job_time,
    input  logic [31:0]  job_target,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic         hash_write_en,
    output logic [255:0] hash_digest_initial,
    output logic [255:0] hash_digest,
    output logic [31:0]  hash_merkle,
    output logic [31:0]  hash_time,
    output logic [31:0]  hash_target,
    output logic [31:0]  hash_nonce,
    input  logic         hash_valid,
    input  logic [31:0]  hash_time_out,
    input  logic [31:0]  hash_nonce_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic [31:0]  res_time,
    output logic         busy,
    output logic [7:0]   status
);
    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
    state_t state, state_next;

    logic [31:0]   nonce_start, nonce_end;
    logic [DW-1:0] drain_cnt;
    logic          discard, alive, found, overflow;
    logic          at_end, roll_ok;
    logic          hit, push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   mem_nonce [FIFO_DEPTH];
    logic [31:0]   mem_time  [FIFO_DEPTH];

    assign at_end = (hash_nonce == nonce_end);

`ifdef NONCE_SCHED_TIME_ROLL_EN
    localparam int RW = (MAX_ROLL > 0) ? $clog2(MAX_ROLL + 1) : 1;
    logic [RW-1:0] roll;

    assign roll_ok = (roll < RW'(MAX_ROLL));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            roll <= '0;
        end else if (state == IDLE && job_valid) begin
            roll <= '0;
        end else if (state == SWEEP && !abort && at_end && roll_ok) begin
            roll <= roll + RW'(1);
        end
    end
`else
    // Rolling compiled out: MAX_ROLL is never negative, so roll_ok is constant 0.
    assign roll_ok = (MAX_ROLL < 0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (job_valid) state_next = SWEEP;
            SWEEP:   if (abort || (at_end && !roll_ok)) state_next = DRAIN;
            DRAIN:   if (drain_cnt <= DW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            job_ready     <= 1'b1;
            busy          <= 1'b0;
            hash_write_en <= 1'b0;
        end else begin
            state         <= state_next;
            job_ready     <= (state_next == IDLE);
            busy          <= (state_next != IDLE);
            hash_write_en <= (state_next == SWEEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hash_digest_initial <= '0;
            hash_digest         <= '0;
            hash_merkle         <= '0;
            hash_time           <= '0;
            hash_target         <= '0;
            hash_nonce          <= '0;
            nonce_start         <= '0;
            nonce_end           <= '0;
            drain_cnt           <= '0;
            discard             <= 1'b0;
            alive               <= 1'b0;
            found               <= 1'b0;
            overflow            <= 1'b0;
        end else begin
            alive <= 1'b1;
            case (state)
                IDLE: if (job_valid) begin
                    hash_digest_initial <= job_midstate;
                    hash_digest         <= job_digest;
                    hash_merkle         <= job_merkle;
                    hash_time           <= job_time;
                    hash_target         <= job_target;
                    hash_nonce          <= job_nonce_start;
                    nonce_start         <= job_nonce_start;
                    nonce_end           <= job_nonce_end;
                    found               <= 1'b0;
                    overflow            <= 1'b0;
                    discard             <= 1'b0;
                end
                SWEEP: begin
                    if (abort) begin
                        drain_cnt <= DW'(PIPE_DEPTH);
                        discard   <= 1'b1;
                    end else if (at_end) begin
                        if (roll_ok) begin
                            hash_nonce <= nonce_start;
                            hash_time  <= hash_time + 32'd1;
                        end else begin
                            drain_cnt <= DW'(PIPE_DEPTH);
                        end
                    end else begin
                        hash_nonce <= hash_nonce + 32'd1;
                    end
                end
                DRAIN: begin
                    if (abort) discard <= 1'b1;
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
                end
                default: ;
            endcase
            if (hit) begin
                found <= 1'b1;
                if (!push) overflow <= 1'b1;
            end
        end
    end

    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    assign hit        = hash_valid && busy && !discard;
    assign pop        = res_valid && res_ready;
    assign push       = hit && ((count != CW'(FIFO_DEPTH)) || pop);
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_nonce[i] <= '0;
                mem_time[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_nonce[wr_ptr] <= hash_nonce_out;
                mem_time[wr_ptr]  <= hash_time_out;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count     <= count_next;
            res_valid <= (count_next != '0);
        end
    end

    assign res_nonce = mem_nonce[rd_ptr];
    assign res_time  = mem_time[rd_ptr];
    assign status    = {alive, 4'b0000, overflow, found, busy};
endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - self-checking bench for nonce_scheduler with a queue-based job/result model
module tb_nonce_scheduler;
    localparam int PIPE_DEPTH = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_ROLL   = 2;
`ifdef NONCE_SCHED_TIME_ROLL_EN
    localparam int ROLLS = MAX_ROLL;
`else
    localparam int ROLLS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         job_valid = 1'b0, job_ready;
    logic [255:0] job_midstate = '0, job_digest = '0;
    logic [31:0]  job_merkle = '0, job_time = '0, job_target = '0;
    logic [31:0]  job_nonce_start = '0, job_nonce_end = '0;
    logic         abort = 1'b0;
    logic         hash_write_en;
    logic [255:0] hash_digest_initial, hash_digest;
    logic [31:0]  hash_merkle, hash_time, hash_target, hash_nonce;
    logic         hash_valid = 1'b0;
    logic [31:0]  hash_time_out = '0, hash_nonce_out = '0;
    logic         res_valid, res_ready = 1'b0;
    logic [31:0]  res_nonce, res_time;
    logic         busy;
    logic [7:0]   status;

    nonce_scheduler #(.PIPE_DEPTH(PIPE_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .MAX_ROLL(MAX_ROLL)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_digest(job_digest), .job_merkle(job_merkle),
        .job_time(job_time), .job_target(job_target),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .abort(abort),
        .hash_write_en(hash_write_en), .hash_digest_initial(hash_digest_initial),
        .hash_digest(hash_digest), .hash_merkle(hash_merkle), .hash_time(hash_time),
        .hash_target(hash_target), .hash_nonce(hash_nonce),
        .hash_valid(hash_valid), .hash_time_out(hash_time_out), .hash_nonce_out(hash_nonce_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_time(res_time),
        .busy(busy), .status(status)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a job expands into the full list of (nonce, time) issues; then PIPE_DEPTH drain cycles.
    logic [31:0]  q_nonce[$], q_time[$], r_nonce[$], r_time[$];
    logic [255:0] m_mid, m_dig;
    logic [31:0]  m_merkle, m_target;
    bit           m_busy, m_alive, m_found, m_ovf, m_discard, m_live;
    int           m_tail;

    always @(posedge clk) begin : model
        bit          do_pop, do_push;
        logic [31:0] len;
        m_live = 1'b1;
        if (!rst_n) begin
            q_nonce.delete(); q_time.delete(); r_nonce.delete(); r_time.delete();
            m_busy = 0; m_alive = 0; m_found = 0; m_ovf = 0; m_discard = 0; m_tail = 0;
        end else begin
            m_alive = 1;
            do_pop  = res_ready && (r_nonce.size() > 0);
            do_push = 0;
            if (m_busy && hash_valid && !m_discard) begin
                m_found = 1;
                if (r_nonce.size() < FIFO_DEPTH || do_pop) do_push = 1;
                else m_ovf = 1;
            end
            if (do_pop) begin
                void'(r_nonce.pop_front());
                void'(r_time.pop_front());
            end
            if (do_push) begin
                r_nonce.push_back(hash_nonce_out);
                r_time.push_back(hash_time_out);
            end
            if (!m_busy) begin
                if (job_valid) begin
                    m_busy = 1; m_tail = PIPE_DEPTH;
                    m_found = 0; m_ovf = 0; m_discard = 0;
                    m_mid = job_midstate; m_dig = job_digest;
                    m_merkle = job_merkle; m_target = job_target;
                    len = job_nonce_end - job_nonce_start + 32'd1;
                    for (int r = 0; r <= ROLLS; r++)
                        for (int unsigned k = 0; k < len; k++) begin
                            q_nonce.push_back(job_nonce_start + 32'(k));
                            q_time.push_back(job_time + 32'(r));
                        end
                end
            end else if (q_nonce.size() > 0) begin
                if (abort) begin
                    q_nonce.delete(); q_time.delete();
                    m_discard = 1;
                end else begin
                    void'(q_nonce.pop_front());
                    void'(q_time.pop_front());
                end
            end else begin
                if (abort) m_discard = 1;
                m_tail--;
                if (m_tail == 0) m_busy = 0;
            end
        end
    end

    int          issue_cnt, busy_cnt;
    logic [31:0] mon_nonce[$], mon_time[$];

    always @(negedge clk) begin : compare
        bit exp_we;
        if (m_live) begin
            exp_we = m_busy && (q_nonce.size() > 0);
            check("job_ready", job_ready, !m_busy);
            check("busy", busy, m_busy);
            check("hash_write_en", hash_write_en, exp_we);
            check("status", status, {m_alive, 4'b0000, m_ovf, m_found, m_busy});
            check("res_valid", res_valid, r_nonce.size() > 0);
            if (exp_we) begin
                check("hash_nonce", hash_nonce, q_nonce[0]);
                check("hash_time", hash_time, q_time[0]);
                check("hash_digest_initial", hash_digest_initial, m_mid);
                check("hash_digest", hash_digest, m_dig);
                check("hash_merkle", hash_merkle, m_merkle);
                check("hash_target", hash_target, m_target);
            end
            if (r_nonce.size() > 0) begin
                check("res_nonce", res_nonce, r_nonce[0]);
                check("res_time", res_time, r_time[0]);
            end
        end
        if (hash_write_en) begin
            issue_cnt++;
            mon_nonce.push_back(hash_nonce);
            mon_time.push_back(hash_time);
        end
        if (busy) busy_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (job_ready !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("idle_timeout", job_ready, 1'b1);
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t);
        issue_cnt = 0;
        busy_cnt  = 0;
        mon_nonce.delete();
        mon_time.delete();
        job_midstate    = {8{s ^ 32'hdeadbeef}};
        job_digest      = {8{e ^ 32'h5a5a1234}};
        job_merkle      = 32'h1234abcd ^ s;
        job_target      = 32'h0000ffff;
        job_time        = t;
        job_nonce_start = s;
        job_nonce_end   = e;
        job_valid       = 1'b1;
        tick();
        job_valid       = 1'b0;
    endtask

    task automatic inject_hit(input logic [31:0] n, input logic [31:0] t);
        hash_valid     = 1'b1;
        hash_nonce_out = n;
        hash_time_out  = t;
        tick();
        hash_valid     = 1'b0;
    endtask

    logic [31:0] wrap_exp[4];
    logic [31:0] roll_exp[$];

    initial begin
        tick(3);
        check("rst_status", status, 8'h00);
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_hash_nonce", hash_nonce, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_status", status, 8'h80);

        start_job(32'h3aeb9bb0, 32'h3aeb9bb3, 32'h130dae51);
        wait_idle();
        check("basic_issues", issue_cnt, 4);
        check("basic_busy_cycles", busy_cnt, 4 + PIPE_DEPTH);
        if (mon_nonce.size() == 4) begin
            check("basic_first_nonce", mon_nonce[0], 32'h3aeb9bb0);
            check("basic_last_nonce", mon_nonce[3], 32'h3aeb9bb3);
        end
        check("basic_status", status, 8'h80);

        start_job(32'h3aeb9bb0, 32'h3aeb9bb3, 32'h130dae51);
        tick(14);
        inject_hit(32'h3aeb9bb2, 32'h130dae51);
        check("hit_res_valid", res_valid, 1'b1);
        check("hit_res_nonce", res_nonce, 32'h3aeb9bb2);
        check("hit_res_time", res_time, 32'h130dae51);
        wait_idle();
        check("hit_status", status, 8'h82);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        wrap_exp = '{32'hfffffffe, 32'hffffffff, 32'h00000000, 32'h00000001};
        start_job(32'hfffffffe, 32'h00000001, 32'h00000777);
        wait_idle();
        check("wrap_issues", issue_cnt, 4 * (ROLLS + 1));
        for (int i = 0; i < 4 && i < mon_nonce.size(); i++)
            check($sformatf("wrap_nonce_%0d", i), mon_nonce[i], wrap_exp[i]);
        check("wrap_status", status, 8'h80);

`ifdef NONCE_SCHED_TIME_ROLL_EN
        roll_exp = '{32'h130dae51, 32'h130dae51, 32'h130dae52, 32'h130dae52, 32'h130dae53, 32'h130dae53};
`else
        roll_exp = '{32'h130dae51, 32'h130dae51};
`endif
        start_job(32'h00000010, 32'h00000011, 32'h130dae51);
        wait_idle();
        check("roll_issues", issue_cnt, roll_exp.size());
        for (int i = 0; i < roll_exp.size() && i < mon_time.size(); i++)
            check($sformatf("roll_time_%0d", i), mon_time[i], roll_exp[i]);

        start_job(32'h0, 32'd99, 32'h00000200);
        tick(2);
        for (int i = 0; i < 5; i++) inject_hit(32'h100 + 32'(i), 32'h200 + 32'(i));
        check("ovf_status_bit", status[2], 1'b1);
        check("ovf_head", res_nonce, 32'h100);
        res_ready = 1'b1;
        inject_hit(32'h105, 32'h205);
        res_ready = 1'b0;
        check("pushpop_head", res_nonce, 32'h101);
        res_ready = 1'b1;
        tick(4);
        res_ready = 1'b0;
        check("fifo_empty", res_valid, 1'b0);
        wait_idle();
        check("ovf_final_status", status, 8'h86);

        start_job(32'h0, 32'd99, 32'h00000300);
        tick(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(5);
        inject_hit(32'h300, 32'h400);
        wait_idle();
        check("abort_issues", issue_cnt, 3);
        check("abort_busy_cycles", busy_cnt, 3 + PIPE_DEPTH);
        check("abort_res_valid", res_valid, 1'b0);
        check("abort_status", status, 8'h80);

        start_job(32'd5, 32'd50, 32'h00000500);
        tick(3);
        rst_n = 1'b0;
        tick();
        check("midrst_job_ready", job_ready, 1'b1);
        check("midrst_write_en", hash_write_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_status", status, 8'h00);
        check("midrst_hash_nonce", hash_nonce, 32'h0);
        check("midrst_hash_time", hash_time, 32'h0);
        check("midrst_digest_initial", hash_digest_initial, 256'h0);
        rst_n = 1'b1;
        tick();
        check("midrst_release_status", status, 8'h80);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
